// File: rtl/memory_stage_if.sv
// Bundles the E/M-register inputs, W-register controls and stage outputs of the memory stage.
// Pure wiring with no logic of its own; all timing is set by the attached stage.
// No backpressure beyond W_stall/W_bubble, which the pipeline control logic drives.
//
// Signals:
//   M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM : instruction presented by the E/M register
//   W_stall, W_bubble                               : W-register hold / NOP-insert controls
//   m_valM, m_stat                                  : combinational read data and stage status
//   W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM : registered M/W pipeline register
// Modports: slave = memory stage, master = upstream driver / consumer of results.
interface memory_stage_if;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  modport slave (
    input  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  modport master (
    output M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 M stage: byte-addressed little-endian data memory access, status generation, M/W register.
// Read data is combinational (m_valM); it reaches W_valM one clock later. Stores land at the posedge.
// W_stall holds the W register and blocks stores; W_bubble loads a NOP; stall wins over bubble.
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset (memory contents are kept)
//   bus        : memory_stage_if.slave carrying the M inputs, W controls and all stage outputs
// Parameters:
//   DMEM_BYTES : data memory size in bytes (power of two); 8-byte access legal for addr <= DMEM_BYTES-8
//   NOP_ICODE  : icode loaded into W on reset or bubble
// Build option:
//   DMEM_ALIGN_CHECK_EN : when defined, any access with addr[2:0] != 0 is an address error
module memory_stage #(
  parameter int          DMEM_BYTES = 1024,
  parameter logic [3:0]  NOP_ICODE  = 4'h1
) (
  input  logic           clk,
  input  logic           reset,
  memory_stage_if.slave  bus
);

  localparam int AW = $clog2(DMEM_BYTES);

  // Highest legal base address of an 8-byte access, as a 64-bit unsigned value.
  localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } wreg_t;

  localparam wreg_t W_NOP = '{
    stat:  STAT_AOK,
    icode: NOP_ICODE,
    valE:  64'd0,
    valM:  64'd0,
    dstE:  4'hF,
    dstM:  4'hF
  };

  // Zero at time 0 in simulation; never cleared by reset.
  logic [7:0]    mem_q [DMEM_BYTES] = '{default: 8'h00};

  logic          is_read;
  logic          is_write;
  logic          access;
  logic [63:0]   addr;
  logic [AW-1:0] base;
  logic          range_err;
  logic          align_err;
  logic          addr_err;
  logic          wr_en;
  logic [63:0]   rd_word;
  logic [63:0]   m_valM;
  logic [2:0]    m_stat;

  wreg_t         w_q;
  wreg_t         w_d;

  // ---------------------------------------------------------------------------
  // Decode: which icodes touch memory and where the address comes from.
  // ret and popq address through valA (old %rsp); everything else uses valE.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = bus.M_valE;
    unique case (bus.M_icode)
      I_MRMOVQ:         is_read  = 1'b1;
      I_RET, I_POPQ: begin
        is_read = 1'b1;
        addr    = bus.M_valA;
      end
      I_RMMOVQ, I_CALL, I_PUSHQ: is_write = 1'b1;
      default: ;
    endcase
  end

  assign access = is_read | is_write;

  // Full 64-bit unsigned compare on the base address; addr+7 is never formed,
  // so huge addresses cannot wrap back into range.
  assign range_err = access && (addr > ADDR_MAX);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = access && (addr[2:0] != 3'b000);
`else
  assign align_err = 1'b0;
`endif

  assign addr_err = range_err | align_err;

  // Only meaningful when addr_err is clear, in which case addr < DMEM_BYTES and
  // base+7 stays inside the array.
  assign base = addr[AW-1:0];

  // ---------------------------------------------------------------------------
  // Combinational little-endian read, byte-granular so unaligned bases work.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem_q[base + AW'(i)];
    end
  end

  assign m_valM = (is_read && !addr_err) ? rd_word : 64'd0;
  assign m_stat = addr_err ? STAT_ADR : bus.M_stat;

  // ---------------------------------------------------------------------------
  // Store: only a healthy, unstalled instruction outside reset may modify memory.
  // A stalled store will be presented again, so writing now would be premature.
  // ---------------------------------------------------------------------------
  assign wr_en = is_write && !addr_err && (bus.M_stat == STAT_AOK) &&
                 !bus.W_stall && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[base + AW'(i)] <= bus.M_valA[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // M/W pipeline register. Priority: reset > stall > bubble > load.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_d       = w_q;
    w_d.stat  = m_stat;
    w_d.icode = bus.M_icode;
    w_d.valE  = bus.M_valE;
    w_d.valM  = m_valM;
    w_d.dstE  = bus.M_dstE;
    w_d.dstM  = bus.M_dstM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= W_NOP;
    end else if (bus.W_stall) begin
      w_q <= w_q;
    end else if (bus.W_bubble) begin
      w_q <= W_NOP;
    end else begin
      w_q <= w_d;
    end
  end

  assign bus.m_valM  = m_valM;
  assign bus.m_stat  = m_stat;
  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.valE;
  assign bus.W_valM  = w_q.valM;
  assign bus.W_dstE  = w_q.dstE;
  assign bus.W_dstM  = w_q.dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage with hand-computed expectations.
// Inputs change 1 ns after a rising edge; combinational outputs are sampled 1 ns later,
// registered outputs 1 ns after the following edge.
module tb_memory_stage;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  memory_stage_if bus();

  memory_stage #(
    .DMEM_BYTES (1024),
    .NOP_ICODE  (4'h1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] stat, input logic [3:0] icode,
                       input logic [63:0] valE, input logic [63:0] valA,
                       input logic [3:0] dstE, input logic [3:0] dstM,
                       input logic stall, input logic bubble);
    bus.M_stat   = stat;
    bus.M_icode  = icode;
    bus.M_valE   = valE;
    bus.M_valA   = valA;
    bus.M_dstE   = dstE;
    bus.M_dstM   = dstM;
    bus.W_stall  = stall;
    bus.W_bubble = bubble;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read 8 bytes at addr through mrmovq and compare the combinational data.
  task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] exp);
    drive(3'd1, 4'h5, a, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    check(tag, bus.m_valM, exp);
    step();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    drive(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    step();
    step();
    check("rst_W_stat",  64'(bus.W_stat),  64'd1);
    check("rst_W_icode", 64'(bus.W_icode), 64'd1);
    check("rst_W_valE",  bus.W_valE,       64'd0);
    check("rst_W_valM",  bus.W_valM,       64'd0);
    check("rst_W_dstE",  64'(bus.W_dstE),  64'hF);
    check("rst_W_dstM",  64'(bus.W_dstM),  64'hF);
    reset = 1'b0;

    // Store then load back.
    drive(3'd1, 4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1'b0, 1'b0);
    check("st_m_stat", 64'(bus.m_stat), 64'd1);
    check("st_m_valM", bus.m_valM, 64'd0);
    step();
    check("st_W_icode", 64'(bus.W_icode), 64'h4);
    check("st_W_valE", bus.W_valE, 64'h10);
    drive(3'd1, 4'h5, 64'h10, 64'd0, 4'hF, 4'h3, 1'b0, 1'b0);
    check("ld_m_valM", bus.m_valM, 64'h1122334455667788);
    check("ld_byte10", bus.m_valM & 64'hFF, 64'h88);
    step();
    check("ld_W_valM", bus.W_valM, 64'h1122334455667788);
    check("ld_W_dstM", 64'(bus.W_dstM), 64'h3);

    // pushq then popq.
    drive(3'd1, 4'hA, 64'h1F8, 64'hABCD, 4'h4, 4'hF, 1'b0, 1'b0);
    step();
    drive(3'd1, 4'hB, 64'h200, 64'h1F8, 4'h4, 4'h0, 1'b0, 1'b0);
    check("pop_m_valM", bus.m_valM, 64'hABCD);
    step();
    check("pop_W_valE", bus.W_valE, 64'h200);
    check("pop_W_valM", bus.W_valM, 64'hABCD);
    check("pop_W_dstM", 64'(bus.W_dstM), 64'h0);

    // Range boundary: 0x3F8 legal, 0x3F9 not.
    drive(3'd1, 4'h5, 64'h3F8, 64'd0, 4'hF, 4'h1, 1'b0, 1'b0);
    check("edge_m_stat", 64'(bus.m_stat), 64'd1);
    check("edge_m_valM", bus.m_valM, 64'd0);
    step();
    drive(3'd1, 4'h5, 64'h3F9, 64'd0, 4'hF, 4'h1, 1'b0, 1'b0);
    check("adr_m_stat", 64'(bus.m_stat), 64'd3);
    check("adr_m_valM", bus.m_valM, 64'd0);
    step();
    check("adr_W_stat", 64'(bus.W_stat), 64'd3);

    // Huge address: must not write (low bits alias 0x3F8).
    drive(3'd1, 4'h4, 64'hFFFFFFFFFFFFFFF8, 64'hDEADBEEF, 4'hF, 4'hF, 1'b0, 1'b0);
    check("huge_m_stat", 64'(bus.m_stat), 64'd3);
    step();
    rd("huge_nowrite", 64'h3F8, 64'd0);

    // Stall / bubble.
    drive(3'd1, 4'h6, 64'h55, 64'd0, 4'h2, 4'hF, 1'b0, 1'b0);
    step();
    check("op_W_icode", 64'(bus.W_icode), 64'h6);
    for (int k = 0; k < 3; k++) begin
      drive(3'd1, 4'h4, 64'h40, 64'h77, 4'hF, 4'hF, 1'b1, 1'b0);
      step();
      check($sformatf("stall%0d_W_icode", k), 64'(bus.W_icode), 64'h6);
      check($sformatf("stall%0d_W_valE", k), bus.W_valE, 64'h55);
    end
    drive(3'd1, 4'h4, 64'h40, 64'h77, 4'hF, 4'hF, 1'b1, 1'b1);
    step();
    check("stbub_W_icode", 64'(bus.W_icode), 64'h6);
    check("stbub_W_dstE", 64'(bus.W_dstE), 64'h2);
    drive(3'd1, 4'h1, 64'h99, 64'd0, 4'h5, 4'h5, 1'b0, 1'b1);
    step();
    check("bub_W_icode", 64'(bus.W_icode), 64'h1);
    check("bub_W_dstE", 64'(bus.W_dstE), 64'hF);
    check("bub_W_dstM", 64'(bus.W_dstM), 64'hF);
    check("bub_W_stat", 64'(bus.W_stat), 64'd1);
    check("bub_W_valE", bus.W_valE, 64'd0);
    rd("stall_nowrite", 64'h40, 64'd0);

    // Status gating: HLT store suppressed.
    drive(3'd2, 4'h4, 64'h20, 64'h99, 4'hF, 4'hF, 1'b0, 1'b0);
    check("hlt_m_stat", 64'(bus.m_stat), 64'd2);
    step();
    check("hlt_W_stat", 64'(bus.W_stat), 64'd2);
    rd("hlt_nowrite", 64'h20, 64'd0);

    // Reset during pushq.
    reset = 1'b1;
    drive(3'd1, 4'hA, 64'h100, 64'h1234, 4'h4, 4'hF, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    check("rstp_W_icode", 64'(bus.W_icode), 64'h1);
    check("rstp_W_dstE", 64'(bus.W_dstE), 64'hF);
    check("rstp_W_stat", 64'(bus.W_stat), 64'd1);
    rd("rstp_nowrite", 64'h100, 64'd0);

    // Unaligned read at 0x13: bytes 55 44 33 22 11 00 00 00.
    drive(3'd1, 4'h5, 64'h13, 64'd0, 4'hF, 4'h2, 1'b0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("ua_m_stat", 64'(bus.m_stat), 64'd3);
    check("ua_m_valM", bus.m_valM, 64'd0);
`else
    check("ua_m_stat", 64'(bus.m_stat), 64'd1);
    check("ua_m_valM", bus.m_valM, 64'h0000001122334455);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
